// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - round-robin I/D arbiter onto one memory request channel, one outstanding transaction
// Optional WAIT-state response timeout: define ARB_TIMEOUT_EN.

module imem_dmem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      i_read,
    input  logic [ADDRESS_BITS-1:0]   i_address,
    output logic                      i_ready,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_data_out,
    output logic [ADDRESS_BITS-1:0]   i_address_out,

    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]     d_data_in,
    output logic                      d_ready,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_data_out,
    output logic [ADDRESS_BITS-1:0]   d_address_out,

    output logic                      mem_read,
    output logic                      mem_write,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
    output logic [ADDRESS_BITS-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    input  logic                      mem_ready,
    input  logic                      mem_valid,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [ADDRESS_BITS-1:0]   mem_address_in,

    output logic                      timeout_error
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_INSTR = 1'b0,
        SIDE_DATA  = 1'b1
    } side_t;

    state_t                    state;
    state_t                    state_next;
    side_t                     last_grant;
    side_t                     owner;
    logic [ADDRESS_BITS-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [BE_W-1:0]           be_q;
    logic                      mem_read_q;
    logic                      mem_write_q;

    logic                      d_req;
    logic                      grant_i;
    logic                      grant_d;
    logic                      resp_fire;
    logic                      timeout_fire;
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_data;
    logic [ADDRESS_BITS-1:0]   resp_addr;

    assign d_req = d_read | d_write;

    // Ready is gated by reset so nothing looks accepted while the block is held in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (reset && state == S_IDLE) begin
            grant_i = i_read && (!d_req || last_grant == SIDE_DATA);
            grant_d = d_req && !grant_i;
        end
    end

    assign i_ready = grant_i;
    assign d_ready = grant_d;

    assign resp_fire = (state == S_WAIT) && mem_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LIMIT = TCW'(TIMEOUT_CYCLES);

    logic [TCW-1:0] tcount;
    logic           timeout_q;

    // A real response arriving in the same cycle as expiry takes priority.
    assign timeout_fire = (state == S_WAIT) && !mem_valid && (tcount == TO_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcount    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_ISSUE && mem_ready)
                tcount <= '0;
            else if (state == S_WAIT && !resp_valid)
                tcount <= tcount + TCW'(1);
            if (timeout_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_error = timeout_q;
`else
    assign timeout_fire  = 1'b0;
    // Feature compiled out: the flag is a constant 0 for any legal TIMEOUT_CYCLES.
    assign timeout_error = (TIMEOUT_CYCLES < 0);
`endif

    assign resp_valid = resp_fire || timeout_fire;
    assign resp_data  = resp_fire ? mem_data_in : '0;
    assign resp_addr  = resp_fire ? mem_address_in : (timeout_fire ? addr_q : '0);

    assign i_valid       = resp_valid && (owner == SIDE_INSTR);
    assign d_valid       = resp_valid && (owner == SIDE_DATA);
    assign i_data_out    = i_valid ? resp_data : '0;
    assign i_address_out = i_valid ? resp_addr : '0;
    assign d_data_out    = d_valid ? resp_data : '0;
    assign d_address_out = d_valid ? resp_addr : '0;

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = (mem_read_q | mem_write_q) ? addr_q : '0;
    assign mem_data_out = mem_write_q ? data_q : '0;
    assign mem_byte_en  = mem_write_q ? be_q : '0;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_i || grant_d) state_next = S_ISSUE;
            S_ISSUE: if (mem_ready)          state_next = S_WAIT;
            S_WAIT:  if (resp_valid)         state_next = S_IDLE;
            default:                         state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch: captured on acceptance, held stable through ISSUE until mem_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant  <= SIDE_DATA;
            owner       <= SIDE_INSTR;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            if (grant_i) begin
                owner       <= SIDE_INSTR;
                last_grant  <= SIDE_INSTR;
                addr_q      <= i_address;
                data_q      <= '0;
                be_q        <= '0;
                mem_read_q  <= 1'b1;
                mem_write_q <= 1'b0;
            end else if (grant_d) begin
                owner       <= SIDE_DATA;
                last_grant  <= SIDE_DATA;
                addr_q      <= d_address;
                data_q      <= d_data_in;
                be_q        <= d_byte_en;
                mem_read_q  <= !d_write;
                mem_write_q <= d_write;
            end else if (state == S_ISSUE && mem_ready) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed self-checking bench for imem_dmem_arbiter

module tb_imem_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_ready, i_valid;
    logic [31:0] i_data_out, i_address_out;
    logic        d_read = 1'b0, d_write = 1'b0;
    logic [3:0]  d_byte_en = '0;
    logic [31:0] d_address = '0, d_data_in = '0;
    logic        d_ready, d_valid;
    logic [31:0] d_data_out, d_address_out;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_address, mem_data_out;
    logic        mem_ready = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_data_in = '0, mem_address_in = '0;
    logic        timeout_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_dmem_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
        .i_data_out(i_data_out), .i_address_out(i_address_out),
        .d_read(d_read), .d_write(d_write), .d_byte_en(d_byte_en), .d_address(d_address),
        .d_data_in(d_data_in), .d_ready(d_ready), .d_valid(d_valid),
        .d_data_out(d_data_out), .d_address_out(d_address_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_data_in(mem_data_in), .mem_address_in(mem_address_in),
        .timeout_error(timeout_error)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; mem_ready = 0; mem_valid = 0;
        i_address = '0; d_address = '0; d_data_in = '0; d_byte_en = '0;
        mem_data_in = '0; mem_address_in = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        reset = 0; i_read = 1; d_read = 1; mem_valid = 1;
        tick();
        sample();
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %b exp 0", i_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %b exp 0", d_ready); end
        checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", i_valid, d_valid); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_mem_req got %b exp 00", {mem_read, mem_write}); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rst_mem_address got %h exp 0", mem_address); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", timeout_error); end
        clear_inputs();
        reset = 1;
        tick();
    endtask

    task automatic test_single_read();
        i_read = 1; i_address = 32'h100; mem_ready = 1;
        sample();
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL sr_ready got %b%b exp 10", i_ready, d_ready); end
        tick();
        i_read = 0;
        sample();
        checks++; if (mem_read !== 1'b1 || mem_address !== 32'h100) begin errors++; $display("FAIL sr_issue got %b %h exp 1 00000100", mem_read, mem_address); end
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL sr_ready_issue got %b exp 0", i_ready); end
        tick();
        sample();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL sr_wait_mem_read got %b exp 0", mem_read); end
        tick();
        tick();
        sample();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL sr_early_valid got %b exp 0", i_valid); end
        tick();
        mem_valid = 1; mem_data_in = 32'h13; mem_address_in = 32'h100;
        sample();
        checks++; if (i_valid !== 1'b1 || i_data_out !== 32'h13) begin errors++; $display("FAIL sr_resp got %b %h exp 1 00000013", i_valid, i_data_out); end
        checks++; if (i_address_out !== 32'h100 || d_valid !== 1'b0) begin errors++; $display("FAIL sr_resp_addr got %h %b exp 00000100 0", i_address_out, d_valid); end
        tick();
        mem_valid = 0;
        sample();
        checks++; if (i_valid !== 1'b0 || i_data_out !== 32'h0) begin errors++; $display("FAIL sr_one_cycle got %b %h exp 0 0", i_valid, i_data_out); end
    endtask

    task automatic test_both_after_reset();
        apply_reset();
        i_read = 1; i_address = 32'h40; d_read = 1; d_address = 32'h80; mem_ready = 1;
        sample();
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL both_first got %b%b exp 10", i_ready, d_ready); end
        tick();
        i_read = 0;
        sample();
        checks++; if (d_ready !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h40) begin errors++; $display("FAIL both_issue_i got %b %b %h exp 0 1 00000040", d_ready, mem_read, mem_address); end
        tick();
        mem_valid = 1; mem_data_in = 32'h11; mem_address_in = 32'h40;
        sample();
        checks++; if (i_valid !== 1'b1 || i_data_out !== 32'h11 || d_valid !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL both_resp_i got %b %h %b %b exp 1 00000011 0 0", i_valid, i_data_out, d_valid, d_ready); end
        tick();
        mem_valid = 0;
        sample();
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL both_second got %b exp 1", d_ready); end
        tick();
        d_read = 0;
        sample();
        checks++; if (mem_read !== 1'b1 || mem_address !== 32'h80) begin errors++; $display("FAIL both_issue_d got %b %h exp 1 00000080", mem_read, mem_address); end
        tick();
        mem_valid = 1; mem_data_in = 32'h22; mem_address_in = 32'h80;
        sample();
        checks++; if (d_valid !== 1'b1 || d_data_out !== 32'h22 || d_address_out !== 32'h80 || i_valid !== 1'b0) begin errors++; $display("FAIL both_resp_d got %b %h %h %b exp 1 00000022 00000080 0", d_valid, d_data_out, d_address_out, i_valid); end
        tick();
        mem_valid = 0;
    endtask

    task automatic test_write_hold();
        mem_ready = 0;
        d_write = 1; d_address = 32'h2000; d_data_in = 32'hDEADBEEF; d_byte_en = 4'b0011;
        sample();
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", d_ready); end
        tick();
        d_write = 0; d_address = '0; d_data_in = '0; d_byte_en = 4'hF;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_hold_req got %b%b exp 10", mem_write, mem_read); end
            checks++; if (mem_address !== 32'h2000 || mem_data_out !== 32'hDEADBEEF || mem_byte_en !== 4'b0011) begin errors++; $display("FAIL wr_hold_payload got %h %h %b exp 00002000 deadbeef 0011", mem_address, mem_data_out, mem_byte_en); end
            tick();
        end
        mem_ready = 1;
        sample();
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wr_accept got %b exp 1", mem_write); end
        tick();
        mem_ready = 0; mem_valid = 1; mem_data_in = '0; mem_address_in = 32'h2000;
        sample();
        checks++; if (mem_write !== 1'b0 || d_valid !== 1'b1 || i_valid !== 1'b0) begin errors++; $display("FAIL wr_ack got %b %b %b exp 0 1 0", mem_write, d_valid, i_valid); end
        tick();
        mem_valid = 0;
    endtask

    task automatic test_round_robin();
        int cnt_i;
        int cnt_d;
        logic exp_i;
        cnt_i = 0;
        cnt_d = 0;
        apply_reset();
        i_read = 1; i_address = 32'h500; d_read = 1; d_address = 32'h600; mem_ready = 1;
        for (int t = 0; t < 16; t++) begin
            exp_i = (t % 2 == 0);
            sample();
            checks++; if (i_ready !== exp_i || d_ready !== !exp_i) begin errors++; $display("FAIL rr_grant_%0d got %b%b exp %b%b", t, i_ready, d_ready, exp_i, !exp_i); end
            if (i_ready === 1'b1) cnt_i++;
            if (d_ready === 1'b1) cnt_d++;
            tick();
            tick();
            mem_valid = 1; mem_data_in = 32'h1000 + t; mem_address_in = exp_i ? 32'h500 : 32'h600;
            sample();
            if (exp_i) begin
                checks++; if (i_valid !== 1'b1 || d_valid !== 1'b0 || i_data_out !== 32'h1000 + t) begin errors++; $display("FAIL rr_resp_%0d got %b%b %h exp 10 %h", t, i_valid, d_valid, i_data_out, 32'h1000 + t); end
            end else begin
                checks++; if (d_valid !== 1'b1 || i_valid !== 1'b0 || d_data_out !== 32'h1000 + t) begin errors++; $display("FAIL rr_resp_%0d got %b%b %h exp 01 %h", t, i_valid, d_valid, d_data_out, 32'h1000 + t); end
            end
            tick();
            mem_valid = 0;
        end
        i_read = 0; d_read = 0;
        checks++; if (cnt_i !== 8 || cnt_d !== 8) begin errors++; $display("FAIL rr_balance got %0d/%0d exp 8/8", cnt_i, cnt_d); end
    endtask

    task automatic test_reset_mid();
        i_read = 1; i_address = 32'h700; mem_ready = 1;
        sample();
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", i_ready); end
        tick();
        i_read = 0;
        tick();
        reset = 0;
        #1;
        mem_valid = 1; mem_data_in = 32'hBAD; mem_address_in = 32'h700; i_read = 1; d_write = 1;
        #1;
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || i_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL rm_in_reset got %b%b%b%b exp 0000", i_ready, d_ready, i_valid, d_valid); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 32'h0) begin errors++; $display("FAIL rm_mem_drop got %b%b %h exp 00 0", mem_read, mem_write, mem_address); end
        tick();
        reset = 1; i_read = 0; d_write = 0;
        sample();
        checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0 || i_data_out !== 32'h0) begin errors++; $display("FAIL rm_late_valid got %b%b %h exp 00 0", i_valid, d_valid, i_data_out); end
        tick();
        mem_valid = 0; i_read = 1; i_address = 32'h704;
        sample();
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL rm_recover got %b exp 1", i_ready); end
        tick();
        clear_inputs();
        mem_ready = 1;
        tick();
        mem_valid = 1; mem_address_in = 32'h704;
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
        apply_reset();
        d_read = 1; d_address = 32'h300; mem_ready = 1;
        tick();
        d_read = 0;
        tick();
        for (int k = 0; k < 8; k++) begin
            sample();
            checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL to_early_%0d got %b exp 0", k, d_valid); end
            tick();
        end
        sample();
        checks++; if (d_valid !== 1'b1 || d_data_out !== 32'h0 || d_address_out !== 32'h300) begin errors++; $display("FAIL to_resp got %b %h %h exp 1 0 00000300", d_valid, d_data_out, d_address_out); end
        tick();
        sample();
        checks++; if (timeout_error !== 1'b1 || d_valid !== 1'b0) begin errors++; $display("FAIL to_flag got %b %b exp 1 0", timeout_error, d_valid); end
`else
        sample();
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_tied got %b exp 0", timeout_error); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_both_after_reset();
        test_write_hold();
        test_round_robin();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
